// File: rtl/hold_gen.sv
// Stall controller for the stage-2/3 control-word register: raises HOLD for memory
// ops and external stall requests, with a guaranteed HOLD-low cycle between stalls.
module hold_gen #(
   parameter int MEM_WAIT = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] M3,
   input  logic       MEM_RDY,
   input  logic       EXT_REQ,
   output logic       HOLD,
   output logic [1:0] MEM_OP,
   output logic [1:0] STATE,
   output logic [7:0] STALL_CNT,
   output logic       TIMEOUT_ERR
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT    = 2'b01,
      EXT     = 2'b10,
      RELEASE = 2'b11
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT - 1);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic [1:0] mem_op_nxt;
   logic       err_nxt;
   logic       mem_req;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign mem_req = (M3 == 2'b01) || (M3 == 2'b10);

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_op_nxt   = MEM_OP;
      err_nxt      = TIMEOUT_ERR;
      case (state)
         IDLE, RELEASE: begin
            // A memory op wins over a simultaneous external request.
            if (mem_req) begin
               state_nxt    = WAIT;
               mem_op_nxt   = M3;
               wait_cnt_nxt = 8'd0;
            end else if (EXT_REQ) begin
               state_nxt = EXT;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            wait_cnt_nxt = sat_inc(wait_cnt);
            if ((wait_cnt >= WAIT_LAST) && MEM_RDY) begin
               state_nxt = RELEASE;
            end else if (wait_cnt == TO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = RELEASE;
            end
         end
         EXT: begin
            if (!EXT_REQ) state_nxt = RELEASE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         MEM_OP      <= 2'b00;
         TIMEOUT_ERR <= 1'b0;
         STALL_CNT   <= 8'd0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         MEM_OP      <= mem_op_nxt;
         TIMEOUT_ERR <= err_nxt;
         if (HOLD) STALL_CNT <= sat_inc(STALL_CNT);
      end
   end

   // HOLD is a pure decode of the state register, so no input reaches it combinationally.
   assign HOLD  = (state == WAIT) || (state == EXT);
   assign STATE = state;

endmodule

// File: tb/tb_hold_gen.sv
// Scoreboard bench for hold_gen: a behavioural model pushes expected outputs when
// stimulus is driven; they are popped and compared one cycle later.
module tb_hold_gen;

   localparam int MEM_WAIT = 2;
   localparam int TIMEOUT  = 8;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] M3;
   logic       MEM_RDY;
   logic       EXT_REQ;
   logic       HOLD;
   logic [1:0] MEM_OP;
   logic [1:0] STATE;
   logic [7:0] STALL_CNT;
   logic       TIMEOUT_ERR;

   hold_gen #(.MEM_WAIT(MEM_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .M3(M3), .MEM_RDY(MEM_RDY), .EXT_REQ(EXT_REQ),
      .HOLD(HOLD), .MEM_OP(MEM_OP), .STATE(STATE), .STALL_CNT(STALL_CNT),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       hold;
      logic [1:0] op;
      logic [1:0] st;
      logic [7:0] cnt;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_pass   = 0;

   // model: mode 0 idle, 1 wait, 2 ext, 3 release; m_n = HOLD-high cycles of current op
   int         m_mode, m_n, m_cnt;
   logic [1:0] m_op;
   logic       m_err;
   int         hi_run, lo_run, last_hi, last_lo;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d want %0d", tag, got, want);
   endtask

   task automatic model_reset();
      m_mode = 0; m_n = 0; m_cnt = 0; m_op = 2'b00; m_err = 1'b0;
      hi_run = 0; lo_run = 0; last_hi = 0; last_lo = 0;
   endtask

   task automatic model_edge(input logic [1:0] m3, input logic ext, input logic rdy);
      exp_t e;
      if (m_mode == 1 || m_mode == 2) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      case (m_mode)
         0, 3: begin
            if (m3 == 2'b01 || m3 == 2'b10) begin
               m_mode = 1; m_op = m3; m_n = 1;
            end else if (ext) m_mode = 2;
            else m_mode = 0;
         end
         1: begin
            if (m_n >= MEM_WAIT && rdy) m_mode = 3;
            else if (m_n == TIMEOUT) begin m_err = 1'b1; m_mode = 3; end
            else m_n++;
         end
         default: if (!ext) m_mode = 3;
      endcase
      e.hold = (m_mode == 1) || (m_mode == 2);
      e.op   = m_op;
      e.st   = 2'(m_mode);
      e.cnt  = 8'(m_cnt);
      e.err  = m_err;
      sb.push_back(e);
   endtask

   task automatic step(input logic [1:0] m3, input logic ext, input logic rdy);
      exp_t e;
      @(negedge CLK);
      M3 = m3; EXT_REQ = ext; MEM_RDY = rdy;
      model_edge(m3, ext, rdy);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check("HOLD", 32'(HOLD), 32'(e.hold));
      check("MEM_OP", 32'(MEM_OP), 32'(e.op));
      check("STATE", 32'(STATE), 32'(e.st));
      check("STALL_CNT", 32'(STALL_CNT), 32'(e.cnt));
      check("TIMEOUT_ERR", 32'(TIMEOUT_ERR), 32'(e.err));
      if (HOLD) begin
         if (lo_run > 0) last_lo = lo_run;
         lo_run = 0;
         hi_run++;
      end else begin
         if (hi_run > 0) last_hi = hi_run;
         hi_run = 0;
         lo_run++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_hold"}, 32'(HOLD), 0);
      check({tag, "_op"}, 32'(MEM_OP), 0);
      check({tag, "_state"}, 32'(STATE), 0);
      check({tag, "_cnt"}, 32'(STALL_CNT), 0);
      check({tag, "_err"}, 32'(TIMEOUT_ERR), 0);
   endtask

   task automatic async_reset(input string tag);
      #1 RST = 1'b1;
      #1 check_reset_vals(tag);
      model_reset();
      #1 RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; M3 = 2'b00; EXT_REQ = 1'b0; MEM_RDY = 1'b0;
      model_reset();
      #2 check_reset_vals("rst0");
      #1 RST = 1'b0;
      repeat (3) step(2'b00, 1'b0, 1'b0);

      // read with ready already high
      step(2'b01, 1'b0, 1'b1);
      repeat (4) step(2'b00, 1'b0, 1'b1);
      check("rd_len", last_hi, 2);
      check("rd_cnt", 32'(STALL_CNT), 2);

      // write, ready arrives late
      step(2'b10, 1'b0, 1'b0);
      repeat (5) step(2'b00, 1'b0, 1'b0);
      repeat (4) step(2'b00, 1'b0, 1'b1);
      check("wr_len", last_hi, 6);
      check("wr_err", 32'(TIMEOUT_ERR), 0);

      // reset in the middle of a stall
      step(2'b01, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      check("pre_rstw_hold", 32'(HOLD), 1);
      async_reset("rstw");
      repeat (2) step(2'b00, 1'b0, 1'b0);

      // timeout
      step(2'b01, 1'b0, 1'b0);
      repeat (12) step(2'b00, 1'b0, 1'b0);
      check("to_len", last_hi, 8);
      check("to_err", 32'(TIMEOUT_ERR), 1);
      repeat (20) step(2'b00, 1'b0, 1'b0);
      check("to_sticky", 32'(TIMEOUT_ERR), 1);
      async_reset("rsti");

      // back-to-back memory ops
      step(2'b01, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b1);
      step(2'b10, 1'b0, 1'b1);
      repeat (4) step(2'b00, 1'b0, 1'b1);
      check("b2b_gap", last_lo, 1);
      check("b2b_len", last_hi, 2);

      // memory op and external request on the same edge
      step(2'b10, 1'b1, 1'b1);
      repeat (6) step(2'b00, 1'b1, 1'b1);
      repeat (3) step(2'b00, 1'b0, 1'b1);
      check("sim_gap", last_lo, 1);
      check("sim_ext_len", last_hi, 4);
      check("sim_op", 32'(MEM_OP), 2);

      // no-op encoding 11 and counter saturation
      repeat (5) step(2'b11, 1'b0, 1'b1);
      check("m3_11", 32'(HOLD), 0);
      repeat (300) step(2'b00, 1'b1, 1'b1);
      repeat (3) step(2'b00, 1'b0, 1'b1);
      check("sat_len", last_hi, 300);
      check("sat_cnt", 32'(STALL_CNT), 255);
      repeat (5) step(2'b11, 1'b0, 1'b1);
      check("sat_hold", 32'(STALL_CNT), 255);
      check("m3_11_idle", 32'(STATE), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hold_gen.md
# hold_gen

Stall controller driving the HOLD input of the stage-2/3 control-word register. It watches the memory-op field leaving stage 3 and an external stall request. It raises HOLD for the number of cycles the data memory or an external agent needs. Between stalls it always returns HOLD low for at least one cycle so the stage register can replay its saved word.

## Interface
- MEM_WAIT, 2: minimum HOLD-high cycles per memory op; legal range 1..254.
- TIMEOUT, 255: maximum HOLD-high cycles waiting for MEM_RDY; must satisfy MEM_WAIT <= TIMEOUT <= 255.
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; one clock, reset is asynchronous and active-high.
- M3  in  2  memory-op field of the stage-3 word: 01 = read, 10 = write, 00 or 11 = no op.
- MEM_RDY  in  1  data memory ready; level, sampled on CLK.
- EXT_REQ  in  1  external stall request; level.
- HOLD  out  1  registered stall request to the stage-2/3 register.
- MEM_OP  out  2  memory op being serviced; holds its last value outside WAIT.
- STATE  out  2  debug state: 00 IDLE, 01 WAIT, 10 EXT, 11 RELEASE.
- STALL_CNT  out  8  total HOLD-high cycles since reset; saturates at 255.
- TIMEOUT_ERR  out  1  sticky; set on memory timeout; cleared only by RST.

## Operation
- State transitions are evaluated at each rising CLK. HOLD = 1 exactly when the registered state is WAIT or EXT.
- **IDLE and RELEASE (identical transitions):**
  - If M3 is 01 or 10: go to WAIT, latch MEM_OP <= M3, clear wait_cnt.
  - Else if EXT_REQ = 1: go to EXT.
  - Else: go to IDLE.
  - A memory op has priority over EXT_REQ when both are present on the same edge.
- **WAIT:**
  - wait_cnt increments each edge and saturates at 255.
  - Exit to RELEASE on the edge where wait_cnt >= MEM_WAIT-1 and MEM_RDY = 1.
  - Otherwise, if wait_cnt = TIMEOUT-1: set TIMEOUT_ERR and go to RELEASE.
  - M3 is ignored in WAIT, because the stage register outputs NOP while HOLD is high.
  - EXT_REQ is not acted on in WAIT; it is evaluated normally in RELEASE.
- **EXT:** stay while EXT_REQ = 1. When EXT_REQ = 0, go to RELEASE.
- **Minimum gap:** WAIT and EXT never transition directly to WAIT or EXT. Every stall is followed by at least one HOLD-low cycle (RELEASE).
- **STALL_CNT:** increments on every edge where the registered HOLD = 1, saturating at 255.
- **Reset:** asynchronous, applied at any time including mid-stall, and has absolute priority.
  - HOLD = 0, STATE = IDLE, MEM_OP = 00, STALL_CNT = 0, TIMEOUT_ERR = 0, wait_cnt = 0.
  - The first evaluation happens on the first rising CLK after RST falls.

## Timing
- Request to HOLD latency: M3 = 01/10 sampled at edge k gives HOLD = 1 from edge k until edge k+n, where n is the number of cycles spent in WAIT.
- HOLD-high length for a memory op:
  - n = MEM_WAIT if MEM_RDY is already high at wait_cnt = MEM_WAIT-1.
  - Otherwise n is the first cycle count >= MEM_WAIT at which MEM_RDY is sampled high.
  - n never exceeds TIMEOUT.
- EXT: EXT_REQ high at edge k gives HOLD high from k. If EXT_REQ is first sampled low at edge j, HOLD falls at j.
- After any stall, HOLD stays low for at least 1 cycle. Back-to-back memory ops produce the sequence HOLD = 1…1, 0, 1…1.
- No combinational path from any input to HOLD.

## Test plan
- **Reset values:** assert RST mid-cycle, both in IDLE and in WAIT. All outputs go to their reset values immediately, without waiting for CLK, and STATE = 00.
- **Memory read, ready already high:** MEM_WAIT = 2, MEM_RDY = 1, M3 = 01 for one cycle. Required: HOLD high exactly 2 cycles, MEM_OP = 01, STATE = 01,01,11,00, STALL_CNT = 2.
- **Memory write with late ready:** MEM_RDY rises 5 cycles after entering WAIT. Required: HOLD high 6 cycles, TIMEOUT_ERR = 0.
- **Timeout:** TIMEOUT = 8, MEM_RDY held 0. Required: HOLD high 8 cycles, then low; TIMEOUT_ERR = 1 and still 1 after 20 further idle cycles.
- **Simultaneous events:** M3 = 10 and EXT_REQ = 1 on the same edge, EXT_REQ held high. Required: WAIT first (2 cycles), then exactly one HOLD-low cycle (RELEASE), then EXT until EXT_REQ drops.
- **Saturation:** EXT_REQ held for 300 cycles. Required: STALL_CNT = 255 and holds there; M3 = 11 in IDLE never causes HOLD.
